// File: rtl/segscan_if.sv
// segscan_if: 6801 peripheral bus seen by the segscan display controller.
interface segscan_if;
   logic [3:0] AD;
   logic [7:0] DI;
   logic [7:0] DO;
   logic       rw;
   logic       cs;
   modport master (output AD, DI, rw, cs, input DO);
   modport slave (input AD, DI, rw, cs, output DO);
endinterface

// File: rtl/segscan.sv
// segscan: bus-attached multiplexed 7-segment display scanner with hex/raw modes,
// per-digit blanking, decimal points, anti-ghosting guard interval and frame counter.
module segscan #(
   parameter int DIGITS       = 4,
   parameter int CLK_HZ       = 6000000,
   parameter int REFRESH_HZ   = 50,
   parameter int GUARD        = 2,
   parameter bit ANODE_ACTIVE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   segscan_if.slave          bus,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg,
   output logic              dp
);
   localparam int DW_RAW = CLK_HZ / (REFRESH_HZ * DIGITS);
   localparam int DWELL  = DW_RAW < GUARD + 2 ? GUARD + 2 : DW_RAW;
   localparam int CW     = $clog2(DWELL);
   localparam int PW     = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic [7:0]        r_data [DIGITS];
   logic              r_en, r_raw, r_dpen;
   logic [7:0]        r_blank, r_dpmask, r_frame;
   logic [PW-1:0]     r_ptr;
   logic [CW-1:0]     r_cnt;
   logic [DIGITS-1:0] r_an;
   logic [6:0]        r_seg;
   logic              r_dp;

   logic              w_wr, w_end, w_wrap, w_lit, w_guard;
   logic [2:0]        w_ptr3;
   logic [7:0]        w_cur, w_rd;
   logic [DIGITS-1:0] w_onehot, w_an;
   logic [6:0]        w_seg;
   logic              w_dp;

   assign w_wr     = bus.cs && !bus.rw;
   assign w_end    = r_cnt == CW'(DWELL - 1);
   assign w_wrap   = r_en && w_end && r_ptr == PW'(DIGITS - 1);
   assign w_guard  = r_cnt < CW'(GUARD);
   assign w_ptr3   = 3'(r_ptr);
   assign w_cur    = r_data[r_ptr];
   assign w_onehot = DIGITS'(1) << r_ptr;
   assign w_lit    = r_en && !w_guard && !r_blank[w_ptr3];
   // Blanked digits keep their dwell slot so the frame period never changes.
   assign w_an     = w_lit ? (ANODE_ACTIVE ? w_onehot : ~w_onehot) : {DIGITS{~ANODE_ACTIVE}};
   assign w_seg    = r_raw ? w_cur[6:0] : HEX[w_cur[3:0]];
   assign w_dp     = r_raw ? w_cur[7] : r_dpen & r_dpmask[w_ptr3];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DIGITS; i++) r_data[i] <= '0;
         {r_dpen, r_raw, r_en} <= 3'b001;
         r_blank  <= '0;
         r_dpmask <= '0;
         r_frame  <= '0;
         r_ptr    <= '0;
         r_cnt    <= '0;
         r_an     <= {DIGITS{~ANODE_ACTIVE}};
         r_seg    <= '0;
         r_dp     <= 1'b0;
      end else begin
         for (int i = 0; i < DIGITS; i++) if (w_wr && bus.AD == 4'(i)) r_data[i] <= bus.DI;
         if (w_wr && bus.AD == 4'd8) {r_dpen, r_raw, r_en} <= bus.DI[2:0];
         if (w_wr && bus.AD == 4'd9) r_blank <= bus.DI;
         if (w_wr && bus.AD == 4'd10) r_dpmask <= bus.DI;
         // A FRAME write beats a coincident frame increment.
         if (w_wr && bus.AD == 4'd11) r_frame <= '0;
         else if (w_wrap) r_frame <= r_frame + 8'd1;
         if (!r_en) begin
            r_cnt <= '0;
            r_ptr <= '0;
         end else if (w_end) begin
            r_cnt <= '0;
            r_ptr <= r_ptr == PW'(DIGITS - 1) ? '0 : r_ptr + PW'(1);
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
         r_an  <= w_an;
         r_seg <= w_seg;
         r_dp  <= w_dp;
      end
   end

   always_comb begin
      w_rd = '0;
      for (int i = 0; i < DIGITS; i++) if (bus.AD == 4'(i)) w_rd = r_data[i];
      if (bus.AD == 4'd8) w_rd = {5'b0, r_dpen, r_raw, r_en};
      if (bus.AD == 4'd9) w_rd = r_blank;
      if (bus.AD == 4'd10) w_rd = r_dpmask;
      if (bus.AD == 4'd11) w_rd = r_frame;
      if (bus.AD == 4'd12) w_rd = {w_guard, 4'b0, w_ptr3};
   end

   assign bus.DO = bus.cs && bus.rw ? w_rd : 8'h00;
   assign an     = r_an;
   assign seg    = r_seg;
   assign dp     = r_dp;
endmodule
